// File: rtl/flash_word_reader.sv
// Services toggle-handshake word reads from an 8-bit parallel NOR flash:
// two byte accesses per request, plus flash reset sequencing after system reset.
module flash_word_reader #(
  parameter int ACCESS_CYCLES = 5,
  parameter int RESET_CYCLES  = 25,
  parameter int BYTE_SWAP     = 0
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic [22:0] iaddr,
  input  logic        ireq,
  output logic        oack,
  output logic [15:0] odata,
  output logic        oready,
  output logic [22:0] ofl_addr,
  input  logic [7:0]  ifl_dq,
  output logic        ofl_ce_n,
  output logic        ofl_oe_n,
  output logic        ofl_we_n,
  output logic        ofl_rst_n,
  output logic        ofl_wp_n
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    IDLE,
    BYTE_HI,
    BYTE_LO
  } state_e;

  localparam logic [7:0] RST_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [3:0]  acnt_q, acnt_d;
  logic        req_s1_q, req_s2_q;
  logic        ack_q, ack_d;
  logic [15:0] data_q, data_d;
  logic [22:0] addr_q, addr_d;
  logic [7:0]  hi_q, hi_d;

  // Word addressing makes the low request bit meaningless.
  logic unused_addr0;
  assign unused_addr0 = iaddr[0];

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state_q  <= RST_HOLD;
      rcnt_q   <= RST_LOAD;
      acnt_q   <= '0;
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      ack_q    <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      acnt_q   <= acnt_d;
      req_s1_q <= ireq;
      req_s2_q <= req_s1_q;
      ack_q    <= ack_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    acnt_d  = acnt_q;
    ack_d   = ack_q;
    data_d  = data_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    case (state_q)
      RST_HOLD: begin
        if (rcnt_q == 8'd0) begin
          state_d = RST_WAIT;
          rcnt_d  = RST_LOAD;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      RST_WAIT: begin
        if (rcnt_q == 8'd0) state_d = IDLE;
        else                rcnt_d  = rcnt_q - 8'd1;
      end
      IDLE: begin
        if (req_s2_q != ack_q) begin
          addr_d  = {iaddr[22:1], 1'b0};
          acnt_d  = ACC_LOAD;
          state_d = BYTE_HI;
        end
      end
      BYTE_HI: begin
        if (acnt_q == 4'd0) begin
          hi_d      = ifl_dq;
          addr_d[0] = 1'b1;
          acnt_d    = ACC_LOAD;
          state_d   = BYTE_LO;
        end else begin
          acnt_d = acnt_q - 4'd1;
        end
      end
      BYTE_LO: begin
        if (acnt_q == 4'd0) begin
          // The even (first-read) byte lands high unless swapping is requested.
          if (BYTE_SWAP != 0) data_d = {ifl_dq, hi_q};
          else                data_d = {hi_q, ifl_dq};
          ack_d   = req_s2_q;
          state_d = IDLE;
        end else begin
          acnt_d = acnt_q - 4'd1;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  always_comb begin
    oready    = (state_q == IDLE);
    ofl_rst_n = (state_q != RST_HOLD);
    ofl_ce_n  = !((state_q == BYTE_HI) || (state_q == BYTE_LO));
    ofl_oe_n  = !((state_q == BYTE_HI) || (state_q == BYTE_LO));
  end

  assign ofl_we_n = 1'b1;
  assign ofl_wp_n = 1'b1;
  assign oack     = ack_q;
  assign odata    = data_q;
  assign ofl_addr = addr_q;

endmodule

// File: tb/tb_flash_word_reader.sv
// Drives two reader instances (normal and byte-swapped) against a hashed flash
// image and compares words, latency and bus activity with a word-level reference.
module tb_flash_word_reader;

  localparam int AC = 5;
  localparam int RC = 25;
  localparam int READ_LAT = 3 + 2 * AC;

  logic        iclk = 1'b0;
  logic        ireset_n;
  logic        ireq;
  logic [22:0] iaddr;
  logic [7:0]  salt;

  logic        oack0, oready0, ce0, oe0, we0, rst0, wp0;
  logic [15:0] odata0;
  logic [22:0] addr0;
  logic [7:0]  dq0;
  logic        oack1, oready1, ce1, oe1, we1, rst1, wp1;
  logic [15:0] odata1;
  logic [22:0] addr1;
  logic [7:0]  dq1;

  int tests = 0;
  int fails = 0;

  always #10 iclk = ~iclk;

  // Flash contents: two fixed bytes, everything else a salted hash of the address.
  function automatic logic [7:0] flashByte(input logic [22:0] a, input logic [7:0] s);
    logic [7:0] v;
    if (a == 23'h000100) return 8'h12;
    if (a == 23'h000101) return 8'h34;
    v = (a[7:0] * 8'd37) ^ a[15:8] ^ {1'b0, a[22:16]} ^ s;
    return v;
  endfunction

  function automatic logic [15:0] refWord(input logic [22:0] a, input bit swap, input logic [7:0] s);
    logic [22:0] evenA, oddA;
    evenA = {a[22:1], 1'b0};
    oddA  = {a[22:1], 1'b1};
    if (swap) return {flashByte(oddA, s), flashByte(evenA, s)};
    return {flashByte(evenA, s), flashByte(oddA, s)};
  endfunction

  assign dq0 = flashByte(addr0, salt);
  assign dq1 = flashByte(addr1, salt);

  flash_word_reader #(.ACCESS_CYCLES(AC), .RESET_CYCLES(RC), .BYTE_SWAP(0)) dut0 (
    .iclk(iclk), .ireset_n(ireset_n), .iaddr(iaddr), .ireq(ireq),
    .oack(oack0), .odata(odata0), .oready(oready0), .ofl_addr(addr0), .ifl_dq(dq0),
    .ofl_ce_n(ce0), .ofl_oe_n(oe0), .ofl_we_n(we0), .ofl_rst_n(rst0), .ofl_wp_n(wp0)
  );

  flash_word_reader #(.ACCESS_CYCLES(AC), .RESET_CYCLES(RC), .BYTE_SWAP(1)) dut1 (
    .iclk(iclk), .ireset_n(ireset_n), .iaddr(iaddr), .ireq(ireq),
    .oack(oack1), .odata(odata1), .oready(oready1), .ofl_addr(addr1), .ifl_dq(dq1),
    .ofl_ce_n(ce1), .ofl_oe_n(oe1), .ofl_we_n(we1), .ofl_rst_n(rst1), .ofl_wp_n(wp1)
  );

  // Toggles a request just after an edge and observes the bus until both acknowledges arrive.
  task automatic issueRead(input logic [22:0] a, output int lat0, output int lat1,
                           output int hiCnt, output int loCnt, output logic [22:0] firstAddr,
                           output bit weBad, output bit addrBad);
    bit gotFirst;
    @(posedge iclk); #1;
    iaddr = a;
    ireq  = ~ireq;
    lat0 = 0; lat1 = 0; hiCnt = 0; loCnt = 0; firstAddr = '0;
    weBad = 0; addrBad = 0; gotFirst = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge iclk); #1;
      if (we0 !== 1'b1 || we1 !== 1'b1) weBad = 1;
      if (ce0 === 1'b0) begin
        if (!gotFirst) begin firstAddr = addr0; gotFirst = 1; end
        if (addr0[22:1] !== a[22:1] || addr1 !== addr0) addrBad = 1;
        if (addr0[0]) loCnt++;
        else          hiCnt++;
      end
      if (lat0 == 0 && oack0 === ireq) lat0 = k;
      if (lat1 == 0 && oack1 === ireq) lat1 = k;
      if (lat0 != 0 && lat1 != 0) break;
    end
  endtask

  // Holds reset for three cycles and leaves the bench just after release edge 0.
  task automatic pulseReset();
    ireset_n = 1'b0;
    ireq     = 1'b0;
    repeat (3) @(posedge iclk);
    #1 ireset_n = 1'b1;
  endtask

  task automatic test_reset();
    int riseRst, riseRdy;
    bit ackBad, strobeBad, glitch;
    ireset_n = 1'b0; ireq = 1'b0; iaddr = '0;
    repeat (3) @(posedge iclk);
    #1;
    tests++;
    if ({oack0, odata0, oready0, addr0, ce0, oe0, we0, rst0, wp0} !==
        {1'b0, 16'h0, 1'b0, 23'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL reset_values0: got %h expected %h",
               {oack0, odata0, oready0, addr0, ce0, oe0, we0, rst0, wp0},
               {1'b0, 16'h0, 1'b0, 23'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    end
    tests++;
    if ({oack1, odata1, oready1, addr1, ce1, oe1, we1, rst1, wp1} !==
        {1'b0, 16'h0, 1'b0, 23'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL reset_values1: got %h", {oack1, odata1, oready1, addr1, ce1, oe1, we1, rst1, wp1});
    end
    ireset_n = 1'b1;
    riseRst = 0; riseRdy = 0; ackBad = 0; strobeBad = 0; glitch = 0;
    for (int k = 1; k <= 2 * RC + 5; k++) begin
      @(posedge iclk); #1;
      if (rst0 === 1'b1 && riseRst == 0) riseRst = k;
      if (oready0 === 1'b1 && riseRdy == 0) riseRdy = k;
      if ((riseRst != 0 && rst0 !== 1'b1) || rst1 !== rst0 || oready1 !== oready0) glitch = 1;
      if (oack0 !== 1'b0 || oack1 !== 1'b0) ackBad = 1;
      if (ce0 !== 1'b1 || ce1 !== 1'b1) strobeBad = 1;
    end
    tests++;
    if (riseRst != RC) begin
      fails++; $display("[TB] FAIL reset_rst_rise: edge %0d expected %0d", riseRst, RC);
    end
    tests++;
    if (riseRdy != 2 * RC) begin
      fails++; $display("[TB] FAIL reset_ready_rise: edge %0d expected %0d", riseRdy, 2 * RC);
    end
    tests++;
    if ({ackBad, strobeBad, glitch} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_quiet: ack/strobe/glitch flags %b expected 000", {ackBad, strobeBad, glitch});
    end
  endtask

  task automatic test_single_read();
    int l0, l1, hc, lc;
    logic [22:0] fa;
    bit wb, ab;
    issueRead(23'h000100, l0, l1, hc, lc, fa, wb, ab);
    tests++;
    if (l0 != READ_LAT || l1 != READ_LAT) begin
      fails++; $display("[TB] FAIL single_latency: got %0d/%0d expected %0d", l0, l1, READ_LAT);
    end
    tests++;
    if (odata0 !== 16'h1234 || oack0 !== 1'b1) begin
      fails++; $display("[TB] FAIL single_data: got %h ack %b expected 1234 ack 1", odata0, oack0);
    end
    tests++;
    if (hc != AC || lc != AC || fa !== 23'h000100 || ab) begin
      fails++; $display("[TB] FAIL single_addr_phases: hi %0d lo %0d first %h bad %b expected %0d %0d 000100 0",
                        hc, lc, fa, ab, AC, AC);
    end
  endtask

  task automatic test_odd_swap();
    int l0, l1, hc, lc;
    logic [22:0] fa;
    bit wb, ab;
    issueRead(23'h000101, l0, l1, hc, lc, fa, wb, ab);
    tests++;
    if (odata1 !== 16'h3412 || oack1 !== ireq) begin
      fails++; $display("[TB] FAIL swap_data: got %h ack %b expected 3412 ack %b", odata1, oack1, ireq);
    end
    tests++;
    if (odata0 !== 16'h1234) begin
      fails++; $display("[TB] FAIL odd_noswap_data: got %h expected 1234", odata0);
    end
    tests++;
    if (fa !== 23'h000100 || ab) begin
      fails++; $display("[TB] FAIL odd_first_addr: got %h expected 000100", fa);
    end
  endtask

  task automatic test_random_reads();
    int l0, l1, hc, lc;
    logic [22:0] fa, a;
    bit wb, ab;
    for (int i = 0; i < 8; i++) begin
      a = 23'($urandom);
      issueRead(a, l0, l1, hc, lc, fa, wb, ab);
      tests++;
      if (odata0 !== refWord(a, 0, salt) || odata1 !== refWord(a, 1, salt)) begin
        fails++; $display("[TB] FAIL random_data @%h: got %h/%h expected %h/%h", a, odata0, odata1,
                          refWord(a, 0, salt), refWord(a, 1, salt));
      end
      tests++;
      if (l0 != READ_LAT || l1 != READ_LAT || ab || hc != AC || lc != AC) begin
        fails++; $display("[TB] FAIL random_timing @%h: lat %0d hi %0d lo %0d bad %b expected %0d %0d %0d 0",
                          a, l0, hc, lc, ab, READ_LAT, AC, AC);
      end
    end
  endtask

  task automatic test_back_to_back();
    int l0, l1, hc, lc;
    logic [22:0] fa, a;
    bit wb, ab;
    for (int i = 0; i < 16; i++) begin
      a = (i < 15) ? 23'(2 * i) : 23'h7FFFFE;
      issueRead(a, l0, l1, hc, lc, fa, wb, ab);
      tests++;
      if (odata0 !== refWord(a, 0, salt) || odata1 !== refWord(a, 1, salt) || l0 != READ_LAT) begin
        fails++; $display("[TB] FAIL b2b_word %0d @%h: got %h/%h lat %0d expected %h/%h lat %0d", i, a,
                          odata0, odata1, l0, refWord(a, 0, salt), refWord(a, 1, salt), READ_LAT);
      end
      tests++;
      if (wb || ab) begin
        fails++; $display("[TB] FAIL b2b_bus %0d: we_bad %b addr_bad %b expected 0 0", i, wb, ab);
      end
    end
    tests++;
    if (fa !== 23'h7FFFFE || hc != AC || lc != AC) begin
      fails++; $display("[TB] FAIL b2b_top_addr: first %h hi %0d lo %0d expected 7ffffe %0d %0d", fa, hc, lc, AC, AC);
    end
  endtask

  task automatic test_early_request();
    int ceLow, ceAfter, ackAt;
    bit early, seenReady;
    logic [22:0] a;
    a = 23'($urandom);
    pulseReset();
    repeat (5) @(posedge iclk);
    #1;
    iaddr = a;
    ireq  = 1'b1;
    early = 0; seenReady = 0; ceLow = 0; ackAt = 0;
    for (int k = 0; k < 4 * RC + 60 && ackAt == 0; k++) begin
      @(posedge iclk); #1;
      if (oready0 === 1'b1) seenReady = 1;
      if (!seenReady && (ce0 !== 1'b1 || oe0 !== 1'b1 || ce1 !== 1'b1)) early = 1;
      if (ce0 === 1'b0) ceLow++;
      if (oack0 === ireq && oack1 === ireq) ackAt = k + 1;
    end
    ceAfter = 0;
    repeat (20) begin
      @(posedge iclk); #1;
      if (ce0 === 1'b0 || ce1 === 1'b0) ceAfter++;
    end
    tests++;
    if (early || ackAt == 0) begin
      fails++; $display("[TB] FAIL early_gate: early strobe %b ack edge %0d expected 0 and nonzero", early, ackAt);
    end
    tests++;
    if (ceLow != 2 * AC || ceAfter != 0 || oack0 !== 1'b1) begin
      fails++; $display("[TB] FAIL early_single_read: ce low %0d after %0d ack %b expected %0d 0 1",
                        ceLow, ceAfter, oack0, 2 * AC);
    end
    tests++;
    if (odata0 !== refWord(a, 0, salt) || odata1 !== refWord(a, 1, salt)) begin
      fails++; $display("[TB] FAIL early_data: got %h/%h expected %h/%h", odata0, odata1,
                        refWord(a, 0, salt), refWord(a, 1, salt));
    end
  endtask

  task automatic test_reset_mid_access();
    bit inLo;
    int riseRst;
    @(posedge iclk); #1;
    iaddr = 23'($urandom);
    ireq  = ~ireq;
    inLo  = 0;
    for (int k = 0; k < 50 && !inLo; k++) begin
      @(posedge iclk); #1;
      if (ce0 === 1'b0 && addr0[0] === 1'b1) inLo = 1;
    end
    tests++;
    if (!inLo) begin
      fails++; $display("[TB] FAIL midreset_reach_lo: got %b expected 1", inLo);
    end
    @(posedge iclk); #1;
    ireset_n = 1'b0;
    ireq     = 1'b0;
    @(posedge iclk); #1;
    tests++;
    if ({ce0, oe0, ce1, oe1} !== 4'b1111) begin
      fails++; $display("[TB] FAIL midreset_strobes: got %b expected 1111", {ce0, oe0, ce1, oe1});
    end
    tests++;
    if (oack0 !== 1'b0 || oack1 !== 1'b0 || odata0 !== 16'h0 || odata1 !== 16'h0) begin
      fails++; $display("[TB] FAIL midreset_outputs: ack %b%b data %h/%h expected 00 0000/0000",
                        oack0, oack1, odata0, odata1);
    end
    tests++;
    if (rst0 !== 1'b0 || oready0 !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_rst_pin: rst_n %b ready %b expected 0 0", rst0, oready0);
    end
    ireset_n = 1'b1;
    riseRst = 0;
    for (int k = 1; k <= RC + 5; k++) begin
      @(posedge iclk); #1;
      if (rst0 === 1'b1 && riseRst == 0) riseRst = k;
    end
    tests++;
    if (riseRst != RC) begin
      fails++; $display("[TB] FAIL midreset_restart: rst rise edge %0d expected %0d", riseRst, RC);
    end
  endtask

  initial begin
    salt = 8'($urandom);
    ireset_n = 1'b0;
    ireq = 1'b0;
    iaddr = '0;
    test_reset();
    test_single_read();
    test_odd_swap();
    test_random_reads();
    test_back_to_back();
    test_early_request();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/flash_word_reader.md
# flash_word_reader

Responder side of the flash toggle request/acknowledge handshake used by the ROM loading path. Accepts a 23-bit word-aligned address on a request toggle, performs two byte reads from the DE2-115 8-bit parallel NOR flash, assembles a 16-bit word, and answers with an acknowledge toggle. It also sequences the flash reset pin after system reset.

## Interface

Parameters:
- ACCESS_CYCLES, 5: clock cycles the address is held per byte before sampling; legal range 2..15. Default gives 100 ns at 50 MHz.
- RESET_CYCLES, 25: cycles `ofl_rst_n` is held low after reset release, and again the recovery wait before the first access; legal range 1..255.
- BYTE_SWAP, 0: 0 places the even byte in `odata[15:8]` (big-endian, Genesis ROM order). 1 places it in `odata[7:0]`.

Ports:
- iclk  in  1  system clock; only clock
- ireset_n  in  1  synchronous, active-low reset
- iaddr  in  23  requested word address; bit 0 ignored; held stable by the requester from its toggle until the acknowledge
- ireq  in  1  request toggle; a new request is any level differing from `oack`
- oack  out  1  acknowledge toggle; equals the serviced request level
- odata  out  16  assembled word; valid when `oack` toggles, held until the next acknowledge
- oready  out  1  high in IDLE only
- ofl_addr  out  23  flash byte address
- ifl_dq  in  8  flash data bus
- ofl_ce_n, ofl_oe_n, ofl_we_n  out  1 each  flash strobes, active low
- ofl_rst_n  out  1  flash reset, active low
- ofl_wp_n  out  1  constant 1

## Operation

- `ireq` passes through a two-flop synchronizer (`req_s1`, `req_s2`). Both flops reset to 0.
- States:
  - RST_HOLD: `ofl_rst_n`=0 for RESET_CYCLES cycles, then go to RST_WAIT.
  - RST_WAIT: `ofl_rst_n`=1; wait RESET_CYCLES cycles, then go to IDLE.
  - IDLE: `oready`=1 and strobes are high. When `req_s2 != oack`, latch `{iaddr[22:1],1'b0}` into `ofl_addr`, drive `ofl_ce_n`=`ofl_oe_n`=0, load the counter to ACCESS_CYCLES-1, and go to BYTE_HI.
  - BYTE_HI: decrement the counter. When it reaches 0, capture `ifl_dq` into the high holding register, set `ofl_addr[0]`=1, reload the counter, and go to BYTE_LO. CE and OE stay low across the transition.
  - BYTE_LO: decrement the counter. When it reaches 0, write `odata` = `{hi, ifl_dq}` (swapped if BYTE_SWAP), set `oack` = `req_s2`, raise CE and OE, and go to IDLE.
- `ofl_we_n` stays 1 in every state. The block never writes the flash.
- A request toggle that arrives during RST_HOLD or RST_WAIT stays pending and is serviced on entry to IDLE.
- A second toggle of `ireq` before `oack` is legal only after the acknowledge. If `ireq` toggles twice while a request is in flight, the block services one read, acknowledges with the current `req_s2` level, and the double toggle is lost. This is a requester protocol violation and the block does not flag it.
- Reset mid-access: all state returns to reset values on the next edge with `ireset_n`=0. The in-flight request is dropped, and `oack` returns to 0.

## Timing

- Reset values: `oack`=0, `odata`=0, `oready`=0, `ofl_addr`=0, `ofl_ce_n`=`ofl_oe_n`=`ofl_we_n`=1, `ofl_rst_n`=0, `ofl_wp_n`=1. The state is RST_HOLD.
- After reset release:
  - `ofl_rst_n` rises at edge RESET_CYCLES.
  - `oready` rises at edge 2·RESET_CYCLES.
- Request latency, with `ireq` toggling before edge 0 and the block in IDLE:
  - `req_s2` updates at edge 2.
  - Address and strobes are driven at edge 3.
  - The high byte is sampled at edge 3+ACCESS_CYCLES.
  - `odata` and `oack` update at edge 3+2·ACCESS_CYCLES, which is edge 13 with defaults.
- Each byte address is stable for exactly ACCESS_CYCLES cycles before sampling.
- `oready` falls at edge 3 and rises at edge 3+2·ACCESS_CYCLES.
- `odata` and `oack` change on the same edge. `odata` is stable for at least two cycles before the requester's synchronized acknowledge sees the toggle.

## Test plan

- Reset sequence: hold `ireset_n`=0 for 3 cycles, then release. Required: `ofl_rst_n` stays 0 for 25 cycles and then goes to 1; `oready` goes to 1 at cycle 50; `oack`=0 throughout.
- Single read: the flash model holds 0x12 at byte 0x000100 and 0x34 at 0x000101. Set `iaddr`=0x000100 and toggle `ireq` 0→1. Required: at edge 13, `odata`=0x1234 and `oack`=1. `ofl_addr` is 0x000100 for 5 cycles, then 0x000101 for 5 cycles.
- Odd address and swap: with BYTE_SWAP=1, set `iaddr`=0x000101 over the same data. Required: byte 0x000100 is read first, and `odata`=0x3412.
- Early request: toggle `ireq` during RST_HOLD. Required: no strobe activity before `oready`. After `oready`, exactly one read completes and `oack` matches `ireq`.
- Back-to-back stream: 16 sequential requests at addresses 0, 2, 4, …, with the requester toggling one cycle after each acknowledge. Required:
  - all 16 words match the model;
  - `ofl_we_n` is 1 throughout;
  - the last address 0x7FFFFE reads bytes 0x7FFFFE and 0x7FFFFF without wrap.
- Reset mid-access: assert `ireset_n`=0 during BYTE_LO. Required:
  - `ofl_ce_n` and `ofl_oe_n` are 1 the next cycle;
  - `oack`=0;
  - `odata`=0;
  - the reset sequence restarts.
